collision_resolver: RTL and testbench

Initiator and consumer side of the per-frame collision handshake. Once per frame, on `start` from the game control FSM, it raises `collision_enable` to the three-enemy collision detector array and collects `done1..3` with their flags. It then applies the results in one resolve cycle: sword damage to enemies, contact damage to the player, invulnerability window. It reports completion with a one-cycle `resolve_done` pulse.

---
 rtl/collision_resolver_if.sv | 35 +++
 rtl/collision_resolver.sv | 232 +++++++++++++++++++++++
 tb/tb_collision_resolver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/collision_resolver_if.sv
// rtl/collision_resolver_if.sv - request/done handshake between the collision resolver and the three-enemy detector array
interface collision_resolver_if;
    logic collision_enable;
    logic done1;
    logic done2;
    logic done3;
    logic c_map_collision;
    logic e1_map_collision;
    logic e2_map_collision;
    logic e3_map_collision;
    logic c_e1_collision;
    logic c_e2_collision;
    logic c_e3_collision;
    logic e1_hit;
    logic e2_hit;
    logic e3_hit;

    modport master (
        output collision_enable,
        input  done1, done2, done3,
        input  c_map_collision,
        input  e1_map_collision, e2_map_collision, e3_map_collision,
        input  c_e1_collision, c_e2_collision, c_e3_collision,
        input  e1_hit, e2_hit, e3_hit
    );

    modport slave (
        input  collision_enable,
        output done1, done2, done3,
        output c_map_collision,
        output e1_map_collision, e2_map_collision, e3_map_collision,
        output c_e1_collision, c_e2_collision, c_e3_collision,
        output e1_hit, e2_hit, e3_hit
    );
endinterface

// File: rtl/collision_resolver.sv
// rtl/collision_resolver.sv - per-frame collision request, done collection and damage resolve
// Optional WAIT watchdog enabled by defining COLLISION_TIMEOUT_EN.
module collision_resolver #(
    parameter int PLAYER_HP     = 6,
    parameter int ENEMY_HP      = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 start,
    collision_resolver_if.master det,
    output logic                 c_map_block,
    output logic [2:0]           e_map_block,
    output logic [3:0]           player_health,
    output logic [2:0]           enemy1_health,
    output logic [2:0]           enemy2_health,
    output logic [2:0]           enemy3_health,
    output logic [2:0]           enemy_alive,
    output logic                 player_dead,
    output logic                 invulnerable,
    output logic                 resolve_done,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESOLVE,
        S_FINISH
    } state_t;

    localparam logic [3:0] HP_INIT  = 4'(PLAYER_HP);
    localparam logic [2:0] EHP_INIT = 3'(ENEMY_HP);
    localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES);

    state_t          state_q, state_d;
    logic [3:0]      player_hp_q, player_hp_d;
    logic [2:0][2:0] enemy_hp_q, enemy_hp_d;
    logic [7:0]      invuln_q, invuln_d;
    logic [2:0]      done_q, done_d;
    logic [2:0]      contact_q, contact_d;
    logic [2:0]      hit_q, hit_d;
    logic [2:0]      emap_q, emap_d;
    logic            cmap_q, cmap_d;

    logic [2:0]      done_in;
    logic [2:0]      contact_in;
    logic [2:0]      hit_in;
    logic [2:0]      emap_in;
    logic [2:0]      alive;
    logic [2:0]      accept;
    logic            all_done;

`ifdef COLLISION_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    assign done_in    = {det.done3, det.done2, det.done1};
    assign contact_in = {det.c_e3_collision, det.c_e2_collision, det.c_e1_collision};
    assign hit_in     = {det.e3_hit, det.e2_hit, det.e1_hit};
    assign emap_in    = {det.e3_map_collision, det.e2_map_collision, det.e1_map_collision};

    // Health only changes in RESOLVE, so alive is stable through a whole frame.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            alive[i] = (enemy_hp_q[i] != 3'd0);
        end
    end

    always_comb begin
        state_d     = state_q;
        player_hp_d = player_hp_q;
        enemy_hp_d  = enemy_hp_q;
        invuln_d    = invuln_q;
        done_d      = done_q;
        contact_d   = contact_q;
        hit_d       = hit_q;
        emap_d      = emap_q;
        cmap_d      = cmap_q;
        accept      = 3'b000;
        all_done    = 1'b0;
`ifdef COLLISION_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                contact_d = 3'b000;
                hit_d     = 3'b000;
                // Dead enemies never report, so count them as already done.
                done_d    = ~alive;
                if (invuln_q != 8'd0) begin
                    invuln_d = invuln_q - 8'd1;
                end
`ifdef COLLISION_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
                state_d = S_WAIT;
            end

            S_WAIT: begin
                accept = done_in & alive;
                for (int i = 0; i < 3; i++) begin
                    if (accept[i]) begin
                        done_d[i]    = 1'b1;
                        contact_d[i] = contact_in[i];
                        hit_d[i]     = hit_in[i];
                        emap_d[i]    = emap_in[i];
                    end
                end
                if (accept[0]) begin
                    cmap_d = det.c_map_collision;
                end
                all_done = &(done_q | accept);
                if (all_done) begin
                    state_d = S_RESOLVE;
                end
`ifdef COLLISION_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_RESOLVE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            S_RESOLVE: begin
                for (int i = 0; i < 3; i++) begin
                    if (alive[i] && hit_q[i]) begin
                        enemy_hp_d[i] = enemy_hp_q[i] - 3'd1;
                    end
                end
                // Any number of contacts in one frame costs a single point.
                if ((|(contact_q & alive)) && (invuln_q == 8'd0) && (player_hp_q != 4'd0)) begin
                    player_hp_d = player_hp_q - 4'd1;
                    invuln_d    = INV_LOAD;
                end
                state_d = S_FINISH;
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (init) begin
            state_d     = S_IDLE;
            player_hp_d = HP_INIT;
            enemy_hp_d  = {3{EHP_INIT}};
            invuln_d    = 8'd0;
            done_d      = 3'b000;
            contact_d   = 3'b000;
            hit_d       = 3'b000;
            emap_d      = 3'b000;
            cmap_d      = 1'b0;
`ifdef COLLISION_TIMEOUT_EN
            wait_cnt_d    = 8'd0;
            timeout_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            player_hp_q <= HP_INIT;
            enemy_hp_q  <= {3{EHP_INIT}};
            invuln_q    <= 8'd0;
            done_q      <= 3'b000;
            contact_q   <= 3'b000;
            hit_q       <= 3'b000;
            emap_q      <= 3'b000;
            cmap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            player_hp_q <= player_hp_d;
            enemy_hp_q  <= enemy_hp_d;
            invuln_q    <= invuln_d;
            done_q      <= done_d;
            contact_q   <= contact_d;
            hit_q       <= hit_d;
            emap_q      <= emap_d;
            cmap_q      <= cmap_d;
        end
    end

`ifdef COLLISION_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign det.collision_enable = (state_q == S_REQ) || (state_q == S_WAIT);
    assign resolve_done         = (state_q == S_FINISH);
    assign c_map_block          = cmap_q;
    assign e_map_block          = emap_q;
    assign player_health        = player_hp_q;
    assign enemy1_health        = enemy_hp_q[0];
    assign enemy2_health        = enemy_hp_q[1];
    assign enemy3_health        = enemy_hp_q[2];
    assign enemy_alive          = alive;
    assign player_dead          = (player_hp_q == 4'd0);
    assign invulnerable         = (invuln_q != 8'd0);

endmodule

// File: tb/tb_collision_resolver.sv
// tb/tb_collision_resolver.sv - directed self-checking bench for collision_resolver
module tb_collision_resolver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       init  = 1'b0;
    logic       start = 1'b0;
    logic       c_map_block;
    logic [2:0] e_map_block;
    logic [3:0] player_health;
    logic [2:0] enemy1_health;
    logic [2:0] enemy2_health;
    logic [2:0] enemy3_health;
    logic [2:0] enemy_alive;
    logic       player_dead;
    logic       invulnerable;
    logic       resolve_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int rd;

    collision_resolver_if det_if ();

    collision_resolver dut (
        .clock         (clock),
        .reset         (reset),
        .init          (init),
        .start         (start),
        .det           (det_if),
        .c_map_block   (c_map_block),
        .e_map_block   (e_map_block),
        .player_health (player_health),
        .enemy1_health (enemy1_health),
        .enemy2_health (enemy2_health),
        .enemy3_health (enemy3_health),
        .enemy_alive   (enemy_alive),
        .player_dead   (player_dead),
        .invulnerable  (invulnerable),
        .resolve_done  (resolve_done),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_det();
        det_if.done1 = 1'b0;
        det_if.done2 = 1'b0;
        det_if.done3 = 1'b0;
        det_if.c_map_collision  = 1'b0;
        det_if.e1_map_collision = 1'b0;
        det_if.e2_map_collision = 1'b0;
        det_if.e3_map_collision = 1'b0;
        det_if.c_e1_collision   = 1'b0;
        det_if.c_e2_collision   = 1'b0;
        det_if.c_e3_collision   = 1'b0;
        det_if.e1_hit = 1'b0;
        det_if.e2_hit = 1'b0;
        det_if.e3_hit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_det();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Cycle 0 carries start; doneN pulses in cycle dN (0 = never).
    // rd returns the cycle in which resolve_done was seen; task ends in IDLE.
    task automatic run_frame(input int d1, input int d2, input int d3, input int req_done,
                             input logic [2:0] hit, input logic [2:0] contact,
                             input logic [2:0] emap, input logic cmap,
                             input int start_cyc, output int rd_cyc);
        int cyc;
        rd_cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (rd_cyc == 0 && cyc < 400) begin
            det_if.done1 = (cyc == d1) || (req_done != 0 && cyc == 1);
            det_if.done2 = (cyc == d2) || (req_done != 0 && cyc == 1);
            det_if.done3 = (cyc == d3) || (req_done != 0 && cyc == 1);
            det_if.e1_hit = hit[0];
            det_if.e2_hit = hit[1];
            det_if.e3_hit = hit[2];
            det_if.c_e1_collision = contact[0];
            det_if.c_e2_collision = contact[1];
            det_if.c_e3_collision = contact[2];
            det_if.e1_map_collision = emap[0];
            det_if.e2_map_collision = emap[1];
            det_if.e3_map_collision = emap[2];
            det_if.c_map_collision  = cmap;
            start = (cyc == start_cyc);
            tick();
            cyc++;
            if (resolve_done) rd_cyc = cyc;
        end
        clear_det();
        start = 1'b0;
        if (rd_cyc == 0) check("frame_bound", 0, 1);
        tick();
    endtask

    initial begin
        do_reset();

        check("rst_player_hp", player_health, 6);
        check("rst_e1_hp", enemy1_health, 3);
        check("rst_e2_hp", enemy2_health, 3);
        check("rst_e3_hp", enemy3_health, 3);
        check("rst_alive", enemy_alive, 7);
        check("rst_enable", det_if.collision_enable, 0);
        check("rst_dead", player_dead, 0);
        check("rst_invuln", invulnerable, 0);
        check("rst_done", resolve_done, 0);
        check("rst_cmap", c_map_block, 0);
        check("rst_emap", e_map_block, 0);
        check("rst_timeout", timeout_err, 0);

        // Hit on enemy2, all dones in cycle 2
        run_frame(2, 2, 2, 0, 3'b010, 3'b000, 3'b010, 1'b1, -1, rd);
        check("hit_rd_cycle", rd, 4);
        check("hit_e2_hp", enemy2_health, 2);
        check("hit_e1_hp", enemy1_health, 3);
        check("hit_player_hp", player_health, 6);
        check("hit_cmap", c_map_block, 1);
        check("hit_emap", e_map_block, 3'b010);
        check("hit_enable_idle", det_if.collision_enable, 0);

        // Staggered dones with two contacts; dones during REQ must be ignored
        run_frame(2, 7, 5, 1, 3'b000, 3'b011, 3'b000, 1'b0, -1, rd);
        check("stag_rd_cycle", rd, 9);
        check("stag_player_hp", player_health, 5);
        check("stag_invuln", invulnerable, 1);
        check("stag_cmap_relatch", c_map_block, 0);
        check("stag_emap_relatch", e_map_block, 0);

        // Consecutive contact frame is absorbed by the invulnerability window
        run_frame(2, 2, 2, 0, 3'b000, 3'b001, 3'b000, 1'b0, -1, rd);
        check("inv_second_hp", player_health, 5);
        for (int i = 0; i < 58; i++) run_frame(2, 2, 2, 0, 3'b000, 3'b000, 3'b000, 1'b0, -1, rd);
        check("inv_still_on", invulnerable, 1);
        for (int i = 0; i < 2; i++) run_frame(2, 2, 2, 0, 3'b000, 3'b000, 3'b000, 1'b0, -1, rd);
        check("inv_expired", invulnerable, 0);
        run_frame(2, 2, 2, 0, 3'b000, 3'b100, 3'b000, 1'b0, -1, rd);
        check("inv_third_hp", player_health, 4);
        check("inv_reload", invulnerable, 1);

        // Kill enemy1, then confirm its flags and done no longer matter
        do_reset();
        for (int i = 0; i < 3; i++) run_frame(2, 2, 2, 0, 3'b001, 3'b000, 3'b000, 1'b0, -1, rd);
        check("dead_e1_hp", enemy1_health, 0);
        check("dead_alive", enemy_alive, 3'b110);
        run_frame(2, 3, 3, 0, 3'b001, 3'b001, 3'b001, 1'b0, -1, rd);
        check("dead_rd_cycle", rd, 5);
        check("dead_contact_ignored", player_health, 6);
        check("dead_hp_saturate", enemy1_health, 0);
        check("dead_emap_ignored", e_map_block, 0);
        run_frame(0, 2, 2, 0, 3'b000, 3'b001, 3'b000, 1'b0, -1, rd);
        check("dead_nodone_rd", rd, 4);
        check("dead_nodone_hp", player_health, 6);

        // Abort with init while waiting
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_enable_wait", det_if.collision_enable, 1);
        init = 1'b1;
        tick();
        init = 1'b0;
        check("abort_enable_drop", det_if.collision_enable, 0);
        check("abort_e1_reload", enemy1_health, 3);
        check("abort_alive", enemy_alive, 7);
        check("abort_player_hp", player_health, 6);
        rd = 0;
        for (int i = 0; i < 6; i++) begin
            det_if.done1 = 1'b1;
            det_if.done2 = 1'b1;
            det_if.done3 = 1'b1;
            tick();
            if (resolve_done) rd = 1;
        end
        clear_det();
        check("abort_no_done", rd, 0);
        check("abort_idle_enable", det_if.collision_enable, 0);

`ifdef COLLISION_TIMEOUT_EN
        // done3 withheld; start reasserted mid-WAIT must not queue a frame
        run_frame(2, 2, 0, 0, 3'b000, 3'b100, 3'b000, 1'b0, 10, rd);
        check("to_rd_cycle", rd, 258);
        check("to_flag", timeout_err, 1);
        check("to_no_flags", player_health, 6);
        tick();
        check("to_start_ignored", det_if.collision_enable, 0);
        init = 1'b1;
        tick();
        init = 1'b0;
        check("to_init_clear", timeout_err, 0);
`else
        check("no_timeout_flag", timeout_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
